mrd_fsmwr_wr: RTL and testbench
===============================

# mrd_FSMwr_wr

Write-back stage of the mixed-radix DFT memory. It takes butterfly results from the radix-2/3/4/5 engine and scatters up to five lanes per beat into the seven interleaved RAM banks. It uses the bank index/address pairs that travel with the data, counts the beats of each stage and pulses `wr_end` after the last write, so the top FSM can leave `Wait_wr_end`. It is the write-side counterpart of the `Rd`-state read path and is instantiated beside it in `mrd_mem_top_v2`.

## Interface
- `wDATA`, 30, width of the real and imaginary parts per lane and per bank.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `fsm`  in  3  top FSM state: Idle=0, Rd=3, Wait_wr_end=4, Source=5.
- `fsm_r`  in  3  `fsm` delayed by one clock.
- `wr_stop`  in  12  beats in the current stage. Nonzero; stable from Rd entry until `wr_end`.
- `in_rdx2345_data`  intf  `mrd_rdx2345_if`  butterfly output. Fields used:
  - `valid`
  - `d_real[0:4]` and `d_imag[0:4]`, `wDATA` each
  - `bank_index[0:4]`, 3 bits each
  - `bank_addr[0:4]`, `wADDR` each
  - `factor`, 3 bits
- `wrRAM_FSMwr`  intf  `mrd_mem_wr`  bank write port. Fields driven:
  - `wren[0:6]`
  - `wraddr[0:6]`, `wADDR` each
  - `din_real[0:6]` and `din_imag[0:6]`, `wDATA` each
- `wr_end`  out  1  one-cycle pulse after the last write of a stage.
- `bank_conflict`  out  1  sticky: two live lanes targeted the same bank in one beat.

## Operation
- A lane k is live when all three hold: `valid`=1, `bank_index[k]`≠7, and k < `factor`. Index 7 means "no bank".
- **Stage 1** registers the following:
  - valid
  - the live-lane mask
  - indices, addresses and data of all five lanes
- **Stage 2**, for each bank b in 0..6:
  - `wren[b]`=1 if any live lane has index b.
  - If so, `wraddr[b]` and `din[b]` come from the lowest-numbered such lane.
  - Otherwise `wren[b]`=0 and `wraddr[b]`/`din[b]`=0.
  - All bank outputs are registered.
- Beat counter `cnt_wr`, 12 bits:
  - Loads 0 when `fsm`==Rd and `fsm_r`≠Rd (stage start).
  - Otherwise it increments on each stage-1 valid beat.
  - When the increment would reach `wr_stop`, it returns to 0 and arms `wr_end`.
  - If clear and valid coincide, the counter ends at 1; if `wr_stop`==1, it ends at 0 and arms `wr_end`.
- `wr_end` is asserted the cycle after the stage-2 `wren` of the final beat.
- Beats beyond `wr_stop` are still written and counted from 0 again; no data is dropped.
- Resets:
  - Reset mid-stage: all pipeline state, counter and outputs go to 0 on the next edge; in-flight beats are lost.
  - Mid-stage Rd re-entry clears only the counter; in-flight writes still complete.
- Width rules:
  - `wraddr` is `bank_addr` passed through unchanged, `wADDR` bits.
  - Data is passed through with no arithmetic.
  - `cnt_wr` compares equal against `wr_stop`; no overflow is possible because `wr_stop` ≤ 4095.

## Timing
- Reset values: `wren`=0, `wraddr`=0, `din_real`/`din_imag`=0, `wr_end`=0, `bank_conflict`=0.
- Input valid at edge t gives `wren`/`wraddr`/`din` at t+2 and `wr_end` at t+3 for the final beat.
- Full throughput: one beat per clock, with no backpressure and no stalls.
- `fsm`/`fsm_r` are sampled at stage 1.

## Configuration
- `MRD_WR_CONFLICT_CHK_EN` defined:
  - Stage 1 compares all lane pairs of live lanes.
  - On any equal pair, `bank_conflict` sets at t+2 and holds until reset.
- `MRD_WR_CONFLICT_CHK_EN` undefined:
  - The comparators are absent and `bank_conflict` is tied to 0.
- Lowest-lane-wins write priority applies in both builds.

## Structure
- `mrd_mem_pkt` holds shared constants: `wADDR`, `NUM_BANKS`=7, `NUM_LANES`=5, and `BANK_NONE`=3'd7.
- Sub-module `mrd_wr_bank_sel` is a per-bank priority selector:
  - Inputs: live mask, indices, addresses, data, and a bank-number parameter.
  - Outputs: that bank's registered `wren`/`wraddr`/`din`.
  - Instantiated 7× in a generate loop.

## Test plan
1. **Radix-5 scatter.**
   - Stimulus: `factor`=5, `wr_stop`=1, one beat with indices {0,1,2,3,4}, addresses {10,11,12,13,14}, distinct data.
   - Response: banks 0–4 written with matching address and data at t+2; banks 5 and 6 idle; `wr_end` at t+3.
2. **Radix-3 masking.**
   - Stimulus: `factor`=3, indices {6,5,4,2,1}.
   - Response: only banks 6, 5 and 4 are written; lanes 3 and 4 are ignored.
3. **Invalid index.**
   - Stimulus: `factor`=4, lane 2 index=7.
   - Response: three writes only; `bank_conflict` stays 0.
4. **Stage count.**
   - Stimulus: `wr_stop`=12, twelve back-to-back beats after Rd entry.
   - Response: exactly one `wr_end` pulse, the cycle after the 12th write; the counter is back at 0.
5. **Conflict.**
   - Stimulus: lanes 1 and 3 both index 2, addresses 7 and 9.
   - Response: bank 2 written with address 7 and lane-1 data.
   - With the macro defined, `bank_conflict` is 1 from t+2 onward; with it undefined, it stays 0.
6. **Reset mid-stage.**
   - Stimulus: assert `rst_n`=0 after 5 of 12 beats, release, re-enter Rd, then send 12 beats.
   - Response: all outputs are 0 during reset; `wr_end` fires only after the 12th new beat.

Source files
------------

// File: rtl/mrd_fsmwr_wr_pkg.sv
// Shared constants, FSM encoding and bus types for the mixed-radix DFT memory
// write-back path.
package mrd_mem_pkt;

    localparam int wDATA     = 30;
    localparam int wADDR     = 10;
    localparam int NUM_BANKS = 7;
    localparam int NUM_LANES = 5;

    localparam logic [2:0] BANK_NONE = 3'd7;

    typedef enum logic [2:0] {
        FSM_IDLE        = 3'd0,
        FSM_RD          = 3'd3,
        FSM_WAIT_WR_END = 3'd4,
        FSM_SOURCE      = 3'd5
    } fsm_e;

    // One butterfly result beat: up to five lanes, each tagged with its bank and address.
    typedef struct packed {
        logic                                 valid;
        logic [2:0]                           factor;
        logic [NUM_LANES-1:0][2:0]            bank_index;
        logic [NUM_LANES-1:0][wADDR-1:0]      bank_addr;
        logic [NUM_LANES-1:0][wDATA-1:0]      d_real;
        logic [NUM_LANES-1:0][wDATA-1:0]      d_imag;
    } mrd_rdx2345_t;

    typedef struct packed {
        logic [NUM_BANKS-1:0]                 wren;
        logic [NUM_BANKS-1:0][wADDR-1:0]      wraddr;
        logic [NUM_BANKS-1:0][wDATA-1:0]      din_real;
        logic [NUM_BANKS-1:0][wDATA-1:0]      din_imag;
    } mrd_mem_wr_t;

endpackage

// File: rtl/mrd_fsmwr_wr_bank_sel.sv
// Per-bank write selector: the lowest-numbered live lane aimed at this bank
// supplies the registered write enable, address and data.
module mrd_wr_bank_sel
    import mrd_mem_pkt::*;
#(
    parameter int BANK = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_LANES-1:0]            live,
    input  logic [NUM_LANES-1:0][2:0]       idx,
    input  logic [NUM_LANES-1:0][wADDR-1:0] addr,
    input  logic [NUM_LANES-1:0][wDATA-1:0] re,
    input  logic [NUM_LANES-1:0][wDATA-1:0] im,
    output logic                            wren,
    output logic [wADDR-1:0]                wraddr,
    output logic [wDATA-1:0]                din_real,
    output logic [wDATA-1:0]                din_imag
);

    localparam logic [2:0] BANK_ID = 3'(BANK);

    logic             hit;
    logic [wADDR-1:0] sel_addr;
    logic [wDATA-1:0] sel_re;
    logic [wDATA-1:0] sel_im;

    // Scan from the top lane down so the lowest matching lane overwrites last.
    always_comb begin
        hit      = 1'b0;
        sel_addr = '0;
        sel_re   = '0;
        sel_im   = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (live[k] && idx[k] == BANK_ID) begin
                hit      = 1'b1;
                sel_addr = addr[k];
                sel_re   = re[k];
                sel_im   = im[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wren     <= 1'b0;
            wraddr   <= '0;
            din_real <= '0;
            din_imag <= '0;
        end else begin
            wren     <= hit;
            wraddr   <= sel_addr;
            din_real <= sel_re;
            din_imag <= sel_im;
        end
    end

endmodule

// File: rtl/mrd_fsmwr_wr.sv
// Write-back stage: scatters butterfly lanes into the seven RAM banks and pulses
// wr_end after the last beat of a stage. MRD_WR_CONFLICT_CHK_EN adds bank-conflict detection.
module mrd_fsmwr_wr
    import mrd_mem_pkt::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   fsm,
    input  logic [2:0]   fsm_r,
    input  logic [11:0]  wr_stop,
    input  mrd_rdx2345_t in_rdx2345_data,
    output mrd_mem_wr_t  wrRAM_FSMwr,
    output logic         wr_end,
    output logic         bank_conflict
);

    logic [NUM_LANES-1:0]            live_in;
    logic                            s1_valid;
    logic                            s1_clr;
    logic [NUM_LANES-1:0]            s1_live;
    logic [NUM_LANES-1:0][2:0]       s1_idx;
    logic [NUM_LANES-1:0][wADDR-1:0] s1_addr;
    logic [NUM_LANES-1:0][wDATA-1:0] s1_re;
    logic [NUM_LANES-1:0][wDATA-1:0] s1_im;

    logic [11:0] cnt_wr;
    logic [11:0] cnt_inc;
    logic        wr_end_arm;

    logic [NUM_BANKS-1:0]            wren_w;
    logic [NUM_BANKS-1:0][wADDR-1:0] wraddr_w;
    logic [NUM_BANKS-1:0][wDATA-1:0] re_w;
    logic [NUM_BANKS-1:0][wDATA-1:0] im_w;

    // Lanes at or above the radix, or tagged with the "no bank" index, never write.
    always_comb begin
        live_in = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            live_in[k] = in_rdx2345_data.valid
                       && (in_rdx2345_data.bank_index[k] != BANK_NONE)
                       && (3'(k) < in_rdx2345_data.factor);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_clr   <= 1'b0;
            s1_live  <= '0;
            s1_idx   <= '0;
            s1_addr  <= '0;
            s1_re    <= '0;
            s1_im    <= '0;
        end else begin
            s1_valid <= in_rdx2345_data.valid;
            s1_clr   <= (fsm == FSM_RD) && (fsm_r != FSM_RD);
            s1_live  <= live_in;
            s1_idx   <= in_rdx2345_data.bank_index;
            s1_addr  <= in_rdx2345_data.bank_addr;
            s1_re    <= in_rdx2345_data.d_real;
            s1_im    <= in_rdx2345_data.d_imag;
        end
    end

    // A stage start that coincides with a valid beat counts that beat as the first.
    assign cnt_inc = (s1_clr ? 12'd0 : cnt_wr) + 12'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_wr     <= '0;
            wr_end_arm <= 1'b0;
            wr_end     <= 1'b0;
        end else begin
            wr_end_arm <= 1'b0;
            wr_end     <= wr_end_arm;
            if (s1_valid) begin
                if (cnt_inc == wr_stop) begin
                    cnt_wr     <= '0;
                    wr_end_arm <= 1'b1;
                end else begin
                    cnt_wr <= cnt_inc;
                end
            end else if (s1_clr) begin
                cnt_wr <= '0;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mrd_wr_bank_sel #(.BANK(b)) u_sel (
            .clk      (clk),
            .rst_n    (rst_n),
            .live     (s1_live),
            .idx      (s1_idx),
            .addr     (s1_addr),
            .re       (s1_re),
            .im       (s1_im),
            .wren     (wren_w[b]),
            .wraddr   (wraddr_w[b]),
            .din_real (re_w[b]),
            .din_imag (im_w[b])
        );
    end

    assign wrRAM_FSMwr = '{wren: wren_w, wraddr: wraddr_w, din_real: re_w, din_imag: im_w};

`ifdef MRD_WR_CONFLICT_CHK_EN
    logic pair_hit;

    always_comb begin
        pair_hit = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int j = i + 1; j < NUM_LANES; j++) begin
                if (s1_live[i] && s1_live[j] && s1_idx[i] == s1_idx[j]) begin
                    pair_hit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_conflict <= 1'b0;
        end else if (pair_hit) begin
            bank_conflict <= 1'b1;
        end
    end
`else
    assign bank_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_mrd_fsmwr_wr.sv
// Bench for mrd_fsmwr_wr: per-beat scatter model with a cycle-indexed expectation
// table, directed scenarios with literal checks, then randomized stages.
module tb_mrd_fsmwr_wr;
    import mrd_mem_pkt::*;

    localparam int N = 2048;
`ifdef MRD_WR_CONFLICT_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   fsm = 3'd0;
    logic [2:0]   fsm_r = 3'd0;
    logic [11:0]  wr_stop = 12'd1;
    mrd_rdx2345_t in_data = '0;
    mrd_mem_wr_t  wr_bus;
    logic         wr_end;
    logic         bank_conflict;

    mrd_fsmwr_wr dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fsm             (fsm),
        .fsm_r           (fsm_r),
        .wr_stop         (wr_stop),
        .in_rdx2345_data (in_data),
        .wrRAM_FSMwr     (wr_bus),
        .wr_end          (wr_end),
        .bank_conflict   (bank_conflict)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs indexed by the cycle in which they must be visible.
    logic [NUM_BANKS-1:0]            exp_wren [N];
    logic [NUM_BANKS-1:0][wADDR-1:0] exp_addr [N];
    logic [NUM_BANKS-1:0][wDATA-1:0] exp_re   [N];
    logic [NUM_BANKS-1:0][wDATA-1:0] exp_im   [N];
    logic                            exp_end  [N];
    logic                            exp_conf [N];

    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt = 0;
    int pulses = 0;
    int pulse_cyc = -1;

    initial begin
        for (int k = 0; k < N; k++) begin
            exp_wren[k] = '0; exp_addr[k] = '0; exp_re[k] = '0; exp_im[k] = '0;
            exp_end[k] = 1'b0; exp_conf[k] = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic finishTest();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // Drive one cycle, fold the beat into the model, and return at the following negedge.
    task automatic applyStimulus(input mrd_rdx2345_t beat, input logic [2:0] f,
                                 input logic [2:0] fr, input logic rn);
        int  c;
        bit  live [NUM_LANES];
        bit  conf;
        @(posedge clk);
        #1;
        in_data = beat;
        fsm     = f;
        fsm_r   = fr;
        rst_n   = rn;
        c = cyc;
        if (c + 3 >= N) begin
            n_fail++;
            $display("[TB] FAIL cycle_budget: reached cycle %0d, limit %0d", c, N - 3);
            finishTest();
        end
        if (!rn) begin
            model_cnt = 0;
            for (int k = c + 1; k < N; k++) begin
                exp_wren[k] = '0; exp_addr[k] = '0; exp_re[k] = '0; exp_im[k] = '0;
                exp_end[k] = 1'b0; exp_conf[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < NUM_LANES; k++)
                live[k] = beat.valid && (beat.bank_index[k] != 3'd7) && (k < int'(beat.factor));
            exp_wren[c+2] = '0; exp_addr[c+2] = '0; exp_re[c+2] = '0; exp_im[c+2] = '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    if (live[k] && int'(beat.bank_index[k]) == b && !exp_wren[c+2][b]) begin
                        exp_wren[c+2][b] = 1'b1;
                        exp_addr[c+2][b] = beat.bank_addr[k];
                        exp_re[c+2][b]   = beat.d_real[k];
                        exp_im[c+2][b]   = beat.d_imag[k];
                    end
                end
            end
            conf = 1'b0;
            for (int i = 0; i < NUM_LANES; i++)
                for (int j = i + 1; j < NUM_LANES; j++)
                    if (live[i] && live[j] && beat.bank_index[i] == beat.bank_index[j]) conf = 1'b1;
            if (conf && CHK)
                for (int k = c + 2; k < N; k++) exp_conf[k] = 1'b1;
            if (f == 3'd3 && fr != 3'd3) model_cnt = 0;
            if (beat.valid) begin
                model_cnt++;
                if (model_cnt == int'(wr_stop)) begin
                    model_cnt = 0;
                    exp_end[c+3] = 1'b1;
                end
            end
        end
        @(negedge clk);
        if (wr_end === 1'b1) begin
            pulses++;
            pulse_cyc = cyc;
        end
    endtask

    function automatic mrd_rdx2345_t mkBeat(input logic v, input int f, input int i0, input int i1,
                                            input int i2, input int i3, input int i4,
                                            input int a0, input int base);
        mrd_rdx2345_t b;
        int idx [NUM_LANES];
        idx = '{i0, i1, i2, i3, i4};
        b = '0;
        b.valid  = v;
        b.factor = 3'(f);
        for (int k = 0; k < NUM_LANES; k++) begin
            b.bank_index[k] = 3'(idx[k]);
            b.bank_addr[k]  = wADDR'(a0 + k);
            b.d_real[k]     = wDATA'(base + k);
            b.d_imag[k]     = wDATA'(base + 100 + k);
        end
        return b;
    endfunction

    function automatic mrd_rdx2345_t rndBeat();
        mrd_rdx2345_t b;
        b = '0;
        b.valid  = ($urandom_range(0, 3) != 0);
        b.factor = 3'($urandom_range(0, 7));
        for (int k = 0; k < NUM_LANES; k++) begin
            b.bank_index[k] = 3'($urandom_range(0, 7));
            b.bank_addr[k]  = wADDR'($urandom());
            b.d_real[k]     = wDATA'($urandom());
            b.d_imag[k]     = wDATA'($urandom());
        end
        return b;
    endfunction

    // Every cycle after the first edge, the full output set must match the model.
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < N) begin
            checkOutput("wren",          256'(wr_bus.wren),     256'(exp_wren[cyc]));
            checkOutput("wraddr",        256'(wr_bus.wraddr),   256'(exp_addr[cyc]));
            checkOutput("din_real",      256'(wr_bus.din_real), 256'(exp_re[cyc]));
            checkOutput("din_imag",      256'(wr_bus.din_imag), 256'(exp_im[cyc]));
            checkOutput("wr_end",        256'(wr_end),          256'(exp_end[cyc]));
            checkOutput("bank_conflict", 256'(bank_conflict),   256'(exp_conf[cyc]));
        end
    end

    initial begin
        mrd_rdx2345_t idle;
        mrd_rdx2345_t beat;
        int c0;
        idle = '0;

        for (int k = 0; k < 3; k++) applyStimulus(idle, 3'd0, 3'd0, 1'b0);
        checkOutput("reset_wren", 256'(wr_bus.wren), 256'(0));
        checkOutput("reset_wr_end", 256'(wr_end), 256'(0));

        // Radix-5 scatter with a single-beat stage.
        wr_stop = 12'd1;
        applyStimulus(mkBeat(1'b1, 5, 0, 1, 2, 3, 4, 10, 1000), 3'd3, 3'd0, 1'b1);
        c0 = cyc;
        applyStimulus(idle, 3'd3, 3'd3, 1'b1);
        applyStimulus(idle, 3'd3, 3'd3, 1'b1);
        checkOutput("t1_wren", 256'(wr_bus.wren), 256'(7'b0011111));
        checkOutput("t1_addr3", 256'(wr_bus.wraddr[3]), 256'(13));
        checkOutput("t1_re4", 256'(wr_bus.din_real[4]), 256'(1004));
        checkOutput("t1_im0", 256'(wr_bus.din_imag[0]), 256'(1100));
        checkOutput("t1_end_early", 256'(wr_end), 256'(0));
        applyStimulus(idle, 3'd3, 3'd3, 1'b1);
        checkOutput("t1_end", 256'(wr_end), 256'(1));
        checkOutput("t1_end_cycle", 256'(cyc - c0), 256'(3));

        // Radix-3 masking: lanes 3 and 4 ignored.
        applyStimulus(mkBeat(1'b1, 3, 6, 5, 4, 2, 1, 20, 2000), 3'd3, 3'd3, 1'b1);
        applyStimulus(idle, 3'd3, 3'd3, 1'b1);
        applyStimulus(idle, 3'd3, 3'd3, 1'b1);
        checkOutput("t2_wren", 256'(wr_bus.wren), 256'(7'b1110000));
        checkOutput("t2_addr6", 256'(wr_bus.wraddr[6]), 256'(20));
        checkOutput("t2_addr1", 256'(wr_bus.wraddr[1]), 256'(0));

        // Invalid index on lane 2.
        applyStimulus(mkBeat(1'b1, 4, 0, 1, 7, 3, 5, 30, 3000), 3'd3, 3'd3, 1'b1);
        applyStimulus(idle, 3'd3, 3'd3, 1'b1);
        applyStimulus(idle, 3'd3, 3'd3, 1'b1);
        checkOutput("t3_wren", 256'(wr_bus.wren), 256'(7'b0001011));
        checkOutput("t3_re3", 256'(wr_bus.din_real[3]), 256'(3003));
        checkOutput("t3_conflict", 256'(bank_conflict), 256'(0));

        // Conflict: lanes 1 and 3 both target bank 2.
        applyStimulus(mkBeat(1'b1, 5, 0, 2, 4, 2, 6, 6, 5000), 3'd3, 3'd3, 1'b1);
        applyStimulus(idle, 3'd3, 3'd3, 1'b1);
        checkOutput("t5_conflict_early", 256'(bank_conflict), 256'(0));
        applyStimulus(idle, 3'd3, 3'd3, 1'b1);
        checkOutput("t5_addr2", 256'(wr_bus.wraddr[2]), 256'(7));
        checkOutput("t5_re2", 256'(wr_bus.din_real[2]), 256'(5001));
        checkOutput("t5_conflict", 256'(bank_conflict), 256'(CHK));
        applyStimulus(idle, 3'd3, 3'd3, 1'b1);
        checkOutput("t5_conflict_hold", 256'(bank_conflict), 256'(CHK));

        // Twelve-beat stage.
        applyStimulus(idle, 3'd4, 3'd4, 1'b1);
        wr_stop = 12'd12;
        pulses = 0;
        applyStimulus(idle, 3'd3, 3'd0, 1'b1);
        for (int k = 0; k < 12; k++)
            applyStimulus(mkBeat(1'b1, 5, k % 7, (k + 1) % 7, (k + 2) % 7, (k + 3) % 7, (k + 4) % 7, k * 5, 6000 + k * 10),
                          3'd3, 3'd3, 1'b1);
        c0 = cyc;
        for (int k = 0; k < 4; k++) applyStimulus(idle, 3'd4, 3'd4, 1'b1);
        checkOutput("t4_pulses", 256'(pulses), 256'(1));
        checkOutput("t4_pulse_cycle", 256'(pulse_cyc - c0), 256'(3));

        // Reset after five of twelve beats, then a clean twelve-beat stage.
        applyStimulus(idle, 3'd3, 3'd0, 1'b1);
        for (int k = 0; k < 5; k++)
            applyStimulus(mkBeat(1'b1, 5, 0, 1, 2, 3, 4, 40 + k, 7000 + k * 10), 3'd3, 3'd3, 1'b1);
        applyStimulus(idle, 3'd3, 3'd3, 1'b0);
        applyStimulus(idle, 3'd3, 3'd3, 1'b0);
        checkOutput("t6_rst_wren", 256'(wr_bus.wren), 256'(0));
        checkOutput("t6_rst_addr", 256'(wr_bus.wraddr), 256'(0));
        checkOutput("t6_rst_conflict", 256'(bank_conflict), 256'(0));
        pulses = 0;
        applyStimulus(idle, 3'd3, 3'd0, 1'b1);
        for (int k = 0; k < 12; k++)
            applyStimulus(mkBeat(1'b1, 5, 4, 3, 2, 1, 0, 50 + k, 8000 + k * 10), 3'd3, 3'd3, 1'b1);
        c0 = cyc;
        for (int k = 0; k < 4; k++) applyStimulus(idle, 3'd4, 3'd4, 1'b1);
        checkOutput("t6_pulses", 256'(pulses), 256'(1));
        checkOutput("t6_pulse_cycle", 256'(pulse_cyc - c0), 256'(3));

        // Randomized stages with occasional Rd re-entry and reset.
        for (int s = 0; s < 20; s++) begin
            for (int k = 0; k < 3; k++) applyStimulus(idle, 3'd4, 3'd4, 1'b1);
            wr_stop = 12'($urandom_range(1, 8));
            applyStimulus(rndBeat(), 3'd3, 3'd0, 1'b1);
            for (int k = 0; k < int'($urandom_range(5, 30)); k++) begin
                int r;
                r = $urandom_range(0, 99);
                beat = rndBeat();
                if (r < 2)      applyStimulus(beat, 3'd3, 3'd3, 1'b0);
                else if (r < 5) applyStimulus(beat, 3'd3, 3'd0, 1'b1);
                else            applyStimulus(beat, 3'd3, 3'd3, 1'b1);
            end
        end
        for (int k = 0; k < 4; k++) applyStimulus(idle, 3'd0, 3'd0, 1'b1);
        finishTest();
    end

endmodule
